ahb_slave_pipe: RTL
===================

# ahb_slave_pipe

AHB-side front end of the AHB-to-APB bridge. It samples the AHB address and data phases, decodes the target APB peripheral and generates `valid`. It also delays address, data and write direction by one and two cycles to build the pipeline the bridge FSM controller consumes (`H_addr1/2`, `H_wdata1/2`, `Hwritereg`, `Temp_selx`). A small burst tracker checks HTRANS/HADDR sequencing and reports protocol errors to the response path.

## Interface
- `ADDR_W`, default 32: AHB address width.
- `DATA_W`, default 32: AHB data width.
- `Hclk` input 1: system clock; all state updates on the rising edge.
- `Hreset` input 1: asynchronous, active-high reset.
- `Hreadyin` input 1: AHB HREADY; high means the current address/data phase is accepted.
- `Htrans` input 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `Hsize` input 3: transfer size, log2 of the byte count.
- `Hwrite` input 1: transfer direction, 1 = write.
- `Haddr` input ADDR_W: address-phase address.
- `Hwdata` input DATA_W: data-phase write data.
- `valid` output 1: combinational; current address phase targets the bridge.
- `Temp_selx` output 3: combinational one-hot peripheral select for `Haddr`.
- `Hwritereg` output 1: `Hwrite` registered on the last accepted cycle.
- `H_addr1`, `H_addr2` output ADDR_W: `Haddr` delayed one and two accepted cycles.
- `H_wdata1`, `H_wdata2` output DATA_W: `Hwdata` delayed one and two accepted cycles.
- `beat_cnt` output 5: accepted beats in the current burst, saturating at 31.
- `seq_err` output 1: one-cycle pulse on an illegal SEQ beat.
- `size_err` output 1: one-cycle pulse on an accepted beat with `Hsize` > 2.

## Operation
- Decode, combinational:
  - 0x8000_0000–0x83FF_FFFF → `Temp_selx` = 001.
  - 0x8400_0000–0x87FF_FFFF → 010.
  - 0x8800_0000–0x8BFF_FFFF → 100.
  - Any other address → 000.
- `valid` = `Hreadyin` & `Htrans[1]` & (`Temp_selx` != 0). BUSY and IDLE never assert `valid`.
- Pipeline: on each edge with `Hreadyin`=1, shift in this order: `H_addr2`←`H_addr1`←`Haddr`, `H_wdata2`←`H_wdata1`←`Hwdata`, `Hwritereg`←`Hwrite`. With `Hreadyin`=0 all pipeline registers hold.
- Accepted beat = `valid` high at a rising edge.
- Burst tracker, states B_IDLE and B_ACTIVE. Registers: `exp_addr`, `burst_dir`.
  - B_IDLE, NONSEQ accepted → B_ACTIVE; `exp_addr` = `Haddr` + (1<<`Hsize`); `burst_dir` = `Hwrite`; `beat_cnt` = 1.
  - B_IDLE, SEQ accepted → `seq_err` pulse; stay in B_IDLE.
  - B_ACTIVE, SEQ accepted with `Haddr` == `exp_addr` and `Hwrite` == `burst_dir` → advance `exp_addr` and increment `beat_cnt`.
  - B_ACTIVE, SEQ accepted with either mismatch → `seq_err` pulse; return to B_IDLE; `beat_cnt` = 0.
  - B_ACTIVE, NONSEQ accepted → restart as from B_IDLE.
  - B_ACTIVE, BUSY or `Hreadyin`=0 → hold all tracker state.
  - B_ACTIVE, IDLE or an out-of-range address phase with `Hreadyin`=1 → B_IDLE; `beat_cnt` = 0.
- Address arithmetic is modulo 2^ADDR_W. A wrap-around past 0xFFFF_FFFF is not an error by itself.
- `size_err` is independent of the tracker. A beat that raises `size_err` still updates the pipeline.
- `seq_err` and `size_err` can both pulse in the same cycle.

## Timing
- Reset values: every registered output is 0 (`H_addr1/2`, `H_wdata1/2`, `Hwritereg`, `beat_cnt`, `seq_err`, `size_err`); tracker state is B_IDLE with `exp_addr` = 0.
- Reset applied mid-burst clears everything immediately (asynchronous). The first beat after reset is treated as new.
- Latency:
  - `valid` and `Temp_selx`: 0 cycles.
  - `H_addr1`, `H_wdata1`, `Hwritereg`: 1 accepted cycle.
  - `H_addr2`, `H_wdata2`: 2 accepted cycles.
  - `seq_err`, `size_err`: registered, high for exactly the cycle after the offending edge.
- `beat_cnt` updates on the accepting edge.
- `Hwdata` is sampled in the data phase, so `H_wdata1` is the data for the address held in `H_addr2`. The bridge FSM relies on this alignment.

## Structure
- Shared bridge package holds:
  - HTRANS encodings.
  - Peripheral base/limit constants and their one-hot select values.
  - The tracker state enum.
- One sub-module, `ahb_addr_decode`: combinational decode producing `Temp_selx` and an in-range flag. The bridge top reuses it.
- Pipeline and tracker stay in this module.

## Test plan
- Reset released, NONSEQ write to 0x8000_0010 with `Hwdata` 0xA5A5_0001 → `valid`=1 and `Temp_selx`=001 in the same cycle; `H_addr1` = 0x8000_0010 one cycle later; `H_wdata1` = 0xA5A5_0001 two cycles later.
- 4-beat INCR word read at 0x8400_0000, BUSY inserted after beat 2 → `Temp_selx`=010; `beat_cnt` goes 1, 2, 2, 3, 4; no errors.
- SEQ to 0x8400_0008 following NONSEQ to 0x8400_0000 with `Hsize`=2 → `seq_err` high for one cycle; `beat_cnt` = 0.
- `Hreadyin` low for 3 cycles mid-burst → `H_addr1/2` and `beat_cnt` frozen; `valid`=0 throughout.
- Access to 0x9000_0000 → `valid`=0 and `Temp_selx`=000. `Hsize`=3 on 0x8800_0000 → `size_err` pulse and `Temp_selx`=100.
- `Hreset` asserted on beat 3 of a burst → all outputs 0 immediately; a following SEQ beat pulses `seq_err`.

Source files
------------

// File: rtl/ahb_slave_pipe_pkg.sv
// ahb_slave_pipe_pkg: shared AHB-to-APB bridge constants, peripheral map and burst tracker states.
package ahb_slave_pipe_pkg;
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [31:0] P0_BASE  = 32'h8000_0000;
    localparam logic [31:0] P0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] P1_BASE  = 32'h8400_0000;
    localparam logic [31:0] P1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] P2_BASE  = 32'h8800_0000;
    localparam logic [31:0] P2_LIMIT = 32'h8BFF_FFFF;
    localparam logic [2:0] SEL_P0   = 3'b001;
    localparam logic [2:0] SEL_P1   = 3'b010;
    localparam logic [2:0] SEL_P2   = 3'b100;
    localparam logic [2:0] SEL_NONE = 3'b000;
    typedef enum logic {B_IDLE, B_ACTIVE} burst_state_e;
endpackage

// File: rtl/ahb_slave_pipe_decode.sv
// ahb_addr_decode: one-hot APB peripheral select and in-range flag for an AHB address.
module ahb_addr_decode
    import ahb_slave_pipe_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [2:0]        o_selx,
    output logic              o_in_range
);
    always_comb begin
        o_selx = (i_addr >= ADDR_W'(P0_BASE) && i_addr <= ADDR_W'(P0_LIMIT)) ? SEL_P0 :
                 (i_addr >= ADDR_W'(P1_BASE) && i_addr <= ADDR_W'(P1_LIMIT)) ? SEL_P1 :
                 (i_addr >= ADDR_W'(P2_BASE) && i_addr <= ADDR_W'(P2_LIMIT)) ? SEL_P2 : SEL_NONE;
        o_in_range = |o_selx;
    end
endmodule

// File: rtl/ahb_slave_pipe.sv
// ahb_slave_pipe: AHB front end of the bridge; decode, address/data pipeline and burst sequencing checker.
module ahb_slave_pipe
    import ahb_slave_pipe_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              Hreadyin,
    input  logic [1:0]        Htrans,
    input  logic [2:0]        Hsize,
    input  logic              Hwrite,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    output logic              valid,
    output logic [2:0]        Temp_selx,
    output logic              Hwritereg,
    output logic [ADDR_W-1:0] H_addr1,
    output logic [ADDR_W-1:0] H_addr2,
    output logic [DATA_W-1:0] H_wdata1,
    output logic [DATA_W-1:0] H_wdata2,
    output logic [4:0]        beat_cnt,
    output logic              seq_err,
    output logic              size_err
);
    burst_state_e      r_state, w_state;
    logic [ADDR_W-1:0] r_exp_addr, w_exp_addr, w_next_addr;
    logic              r_burst_dir, w_burst_dir, w_in_range, w_seq_err;
    logic [4:0]        w_beat_cnt;

    ahb_addr_decode #(.ADDR_W(ADDR_W)) u_decode (
        .i_addr     (Haddr),
        .o_selx     (Temp_selx),
        .o_in_range (w_in_range)
    );

    assign valid       = Hreadyin & Htrans[1] & w_in_range;
    assign w_next_addr = Haddr + (ADDR_W'(1) << Hsize);

    // Hwdata lags its address by one phase, so H_wdata1 pairs with H_addr2.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            H_addr1   <= '0;
            H_addr2   <= '0;
            H_wdata1  <= '0;
            H_wdata2  <= '0;
            Hwritereg <= 1'b0;
        end else if (Hreadyin) begin
            H_addr2   <= H_addr1;
            H_addr1   <= Haddr;
            H_wdata2  <= H_wdata1;
            H_wdata1  <= Hwdata;
            Hwritereg <= Hwrite;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_exp_addr  = r_exp_addr;
        w_burst_dir = r_burst_dir;
        w_beat_cnt  = beat_cnt;
        w_seq_err   = 1'b0;
        if (valid && Htrans == HT_NONSEQ) begin
            w_state     = B_ACTIVE;
            w_exp_addr  = w_next_addr;
            w_burst_dir = Hwrite;
            w_beat_cnt  = 5'd1;
        end else if (valid) begin
            if (r_state == B_ACTIVE && Haddr == r_exp_addr && Hwrite == r_burst_dir) begin
                w_exp_addr = w_next_addr;
                w_beat_cnt = (beat_cnt == 5'd31) ? beat_cnt : beat_cnt + 5'd1;
            end else begin
                w_seq_err  = 1'b1;
                w_state    = B_IDLE;
                w_beat_cnt = 5'd0;
            end
        end else if (Hreadyin && Htrans != HT_BUSY) begin
            w_state    = B_IDLE;
            w_beat_cnt = 5'd0;
        end
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_state     <= B_IDLE;
            r_exp_addr  <= '0;
            r_burst_dir <= 1'b0;
            beat_cnt    <= 5'd0;
            seq_err     <= 1'b0;
            size_err    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_exp_addr  <= w_exp_addr;
            r_burst_dir <= w_burst_dir;
            beat_cnt    <= w_beat_cnt;
            seq_err     <= w_seq_err;
            size_err    <= valid && Hsize > 3'd2;
        end
    end
endmodule
